// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder.
// Samples two WIDTH-bit operands, adds them LSB-first through one full adder
// and a carry flip-flop, then presents the registered (WIDTH+1)-bit sum.
// Runs continuously: each operation is one LOAD edge, WIDTH ADD edges and one
// DONE edge, so a new result appears every WIDTH+2 clocks.
// Optional build macro SERIAL_ADDER_DONE_EN adds a one-cycle 'done' output
// that is high in the cycle after each DONE edge, coincident with sum updating.
// WIDTH must be at least 2.

module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
`ifdef SERIAL_ADDER_DONE_EN
    output logic             done,
`endif
    output logic [WIDTH:0]   sum
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        LOAD = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [WIDTH-1:0]   r_aSr;
    logic [WIDTH-1:0]   r_bSr;
    logic [WIDTH-1:0]   r_resSr;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     r_sum;

    logic               w_aBit;
    logic               w_bBit;
    logic               w_sumBit;
    logic               w_carryNext;
    logic               w_lastBit;

    // The single full adder works on the current LSBs of the operand shifters.
    assign w_aBit      = r_aSr[0];
    assign w_bBit      = r_bSr[0];
    assign w_sumBit    = w_aBit ^ w_bBit ^ r_carry;
    assign w_carryNext = (w_aBit & w_bBit) | (w_aBit & r_carry) | (w_bBit & r_carry);
    assign w_lastBit   = (r_cnt == CNT_W'(WIDTH - 1));

    // State register; reset and any recovery always restart at LOAD.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Sequencing: one load edge, WIDTH add edges, one result edge; unused codes fall back to LOAD.
    always_comb begin
        w_nextState = LOAD;
        case (r_state)
            LOAD:    w_nextState = ADD;
            ADD:     w_nextState = w_lastBit ? DONE : ADD;
            DONE:    w_nextState = LOAD;
            default: w_nextState = LOAD;
        endcase
    end

    // Operand shifters capture x/y only at LOAD, then shift right with zero fill while adding.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_aSr <= '0;
            r_bSr <= '0;
        end else if (r_state == LOAD) begin
            r_aSr <= x;
            r_bSr <= y;
        end else if (r_state == ADD) begin
            r_aSr <= r_aSr >> 1;
            r_bSr <= r_bSr >> 1;
        end
    end

    // Carry is cleared for each new operation and then follows the full-adder majority.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_carry <= 1'b0;
        end else if (r_state == LOAD) begin
            r_carry <= 1'b0;
        end else if (r_state == ADD) begin
            r_carry <= w_carryNext;
        end
    end

    // Sum bits enter at the MSB so after WIDTH shifts the LSB sits at bit 0.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_resSr <= '0;
        end else if (r_state == ADD) begin
            r_resSr <= {w_sumBit, r_resSr[WIDTH-1:1]};
        end
    end

    // Bit counter decides when the last operand bit has been consumed.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (r_state == LOAD) begin
            r_cnt <= '0;
        end else if (r_state == ADD) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Output register only changes on DONE, so sum never glitches or sees x/y directly.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= '0;
        end else if (r_state == DONE) begin
            r_sum <= {r_carry, r_resSr};
        end
    end

    assign sum = r_sum;

`ifdef SERIAL_ADDER_DONE_EN
    logic r_done;

    // Completion strobe is high exactly in the cycle that follows a DONE edge.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
        end
    end

    assign done = r_done;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: table-driven vectors, hand-written corner
// sequences and a randomized run checked against a timeline model that
// computes x+y at every operation start and expects it WIDTH+1 edges later.

module tb_serial_adder;

    localparam int W      = 4;
    localparam int PERIOD = W + 2;

    logic           CLK = 1'b0;
    logic           reset_n;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [W:0]     sum;
`ifdef SERIAL_ADDER_DONE_EN
    logic           done;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   expSum;
    } vec_t;

    vec_t vecs [7];

    serial_adder #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .x       (x),
        .y       (y),
`ifdef SERIAL_ADDER_DONE_EN
        .done    (done),
`endif
        .sum     (sum)
    );

    // Free-running clock, period 10.
    always #5 CLK = ~CLK;

    // Reference model: operations start every PERIOD edges after reset release,
    // the sum of the operands seen at a start edge appears PERIOD-1 edges later.
    int           edgeIdx;
    logic [W:0]   pendSum;
    logic [W:0]   modelSum;
    logic         modelDone;

    always @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            edgeIdx   <= 0;
            pendSum   <= '0;
            modelSum  <= '0;
            modelDone <= 1'b0;
        end else begin
            if (edgeIdx % PERIOD == 0) begin
                pendSum <= {1'b0, x} + {1'b0, y};
            end
            if (edgeIdx % PERIOD == PERIOD - 1) begin
                modelSum <= pendSum;
            end
            modelDone <= (edgeIdx % PERIOD == PERIOD - 1);
            edgeIdx   <= edgeIdx + 1;
        end
    end

    // Drive both operands.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        x = a;
        y = b;
    endtask

    // Compare one value and report any difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // Check the optional completion strobe when it exists.
    task automatic checkDone(input string name, input logic exp);
`ifdef SERIAL_ADDER_DONE_EN
        checkOutput(name, {31'd0, done}, {31'd0, exp});
`else
        if (exp === 1'bx) $display("[TB] unused %s", name);
`endif
    endtask

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W:0] prevExp;

        vecs[0] = '{a: 4'b1010, b: 4'b0111, expSum: 5'b10001};
        vecs[1] = '{a: 4'b1111, b: 4'b1111, expSum: 5'b11110};
        vecs[2] = '{a: 4'b0000, b: 4'b0000, expSum: 5'b00000};
        vecs[3] = '{a: 4'b1111, b: 4'b0001, expSum: 5'b10000};
        vecs[4] = '{a: 4'b1000, b: 4'b1000, expSum: 5'b10000};
        vecs[5] = '{a: 4'b0110, b: 4'b1011, expSum: 5'b10001};
        vecs[6] = '{a: 4'b0001, b: 4'b0000, expSum: 5'b00001};

        // Reset held with clock running.
        reset_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000);
        repeat (3) begin
            @(negedge CLK);
            checkOutput("resetSum", {27'd0, sum}, 32'd0);
            checkDone("resetDone", 1'b0);
        end
        reset_n = 1'b1;

        // Back-to-back operations from the table; the next posedge is the first LOAD.
        prevExp = '0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b);
            repeat (3) @(posedge CLK);
            @(negedge CLK);
            checkOutput("holdSum", {27'd0, sum}, {27'd0, prevExp});
            checkDone("holdDone", 1'b0);
            repeat (3) @(posedge CLK);
            @(negedge CLK);
            checkOutput("vecSum", {27'd0, sum}, {27'd0, vecs[i].expSum});
            checkOutput("vecModel", {27'd0, sum}, {27'd0, modelSum});
            checkDone("vecDone", 1'b1);
            prevExp = vecs[i].expSum;
        end

        // Asynchronous reset between edges clears sum without an edge.
        @(posedge CLK);
        #3;
        checkOutput("preResetSum", {27'd0, sum}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("asyncResetSum", {27'd0, sum}, 32'd0);
        checkDone("asyncResetDone", 1'b0);
        @(negedge CLK);
        reset_n = 1'b1;

        // Operands changed right after the LOAD edge do not disturb the operation in flight.
        applyStimulus(4'b1010, 4'b0111);
        @(posedge CLK);
        #1;
        applyStimulus(4'b1111, 4'b1111);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        checkOutput("inFlightSum", {27'd0, sum}, 32'd17);
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        checkOutput("nextOpSum", {27'd0, sum}, 32'd30);

        // Reset pulse during ADD discards the partial result.
        applyStimulus(4'b0101, 4'b0011);
        @(posedge CLK);
        @(posedge CLK);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("midAddResetSum", {27'd0, sum}, 32'd0);
        @(negedge CLK);
        reset_n = 1'b1;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        checkOutput("beforeFirstDone", {27'd0, sum}, 32'd0);
        checkDone("beforeFirstDoneStrobe", 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("afterReleaseSum", {27'd0, sum}, 32'd8);
        checkDone("afterReleaseDone", 1'b1);

        // Randomized operands changing at arbitrary cycles, with one reset pulse.
        for (int i = 0; i < 240; i++) begin
            @(negedge CLK);
            checkOutput("randSum", {27'd0, sum}, {27'd0, modelSum});
            checkDone("randDone", modelDone);
            if (i == 100) reset_n = 1'b0;
            if (i == 103) reset_n = 1'b1;
            if ($urandom_range(0, 2) != 0) begin
                applyStimulus(W'($urandom), W'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
